hiscore_bridge_buffer: RTL and testbench

// Bridge leaf holding the game's high-score table in on-chip RAM, feeding hs_selected/hs_rd_data into
// the user_top bridge read mux. APF host loads/reads the table over the bridge (big-endian words);
// the game core reads/writes it bytewise. Tracks core-side modifications and raises a save request

---
 rtl/hiscore_bridge_buffer.sv | 133 +++++++++++++
 tb/tb_hiscore_bridge_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_bridge_buffer.sv
// High-score table RAM shared by the APF bridge (32-bit big-endian words) and the core (bytes); both reads registered, 1 cycle.
// No backpressure: every strobe completes in its cycle; save_req holds until save_ack once core writes have gone quiet.
module hiscore_bridge_buffer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          IDLE_CYCLES = 74_250_000,
  parameter int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_74a,
  input  logic              reset_n,
  input  logic [31:0]       bridge_addr,
  input  logic              bridge_wr,
  input  logic [31:0]       bridge_wr_data,
  input  logic              bridge_rd,
  output logic              hs_selected,
  output logic [31:0]       hs_rd_data,
  input  logic [ADDR_W+1:0] core_addr,
  input  logic              core_wr,
  input  logic [7:0]        core_wr_data,
  output logic [7:0]        core_rd_data,
  output logic              save_req,
  input  logic              save_ack,
  output logic              dirty
);

  localparam int              CNT_W     = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_CLEAN, ST_DIRTY, ST_REQ} state_e;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] br_idx;
  logic [ADDR_W-1:0] core_idx;
  logic [4:0]        core_lane;
  logic              br_we;
  logic              core_we;
  logic [31:0]       core_word;

  logic [31:0]       hs_rd_data_d, hs_rd_data_q;
  logic [7:0]        core_rd_data_d, core_rd_data_q;
  state_e            state_d, state_q;
  logic [CNT_W-1:0]  idle_cnt_d, idle_cnt_q;
  logic              pending_d, pending_q;

  logic              unused_bits;
  assign unused_bits = &{1'b0, bridge_rd, bridge_addr[1:0]};

  assign hs_selected = (bridge_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign br_idx      = bridge_addr[ADDR_W+1:2];
  assign core_idx    = core_addr[ADDR_W+1:2];
  // Byte 0 lives in bits [31:24], so the lane offset is (3 - byte) * 8.
  assign core_lane   = {~core_addr[1:0], 3'b000};
  assign br_we       = bridge_wr && hs_selected;
  assign core_we     = core_wr && !(br_we && (br_idx == core_idx));

  // Table contents deliberately survive reset so the host copy is not lost.
  always_ff @(posedge clk_74a) begin
    if (br_we) begin
      mem[br_idx] <= bridge_wr_data;
    end
    if (core_we) begin
      mem[core_idx][core_lane +: 8] <= core_wr_data;
    end
  end

  always_comb begin
    hs_rd_data_d   = mem[br_idx];
    core_word      = mem[core_idx];
    core_rd_data_d = core_word[core_lane +: 8];
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    pending_d  = pending_q;
    case (state_q)
      ST_CLEAN: begin
        if (core_wr) begin
          state_d    = ST_DIRTY;
          idle_cnt_d = '0;
        end
      end
      ST_DIRTY: begin
        if (core_wr) begin
          idle_cnt_d = '0;
        end else begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = ST_REQ;
          end
          if (idle_cnt_q != CNT_MAX) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REQ: begin
        // A core write racing the ack means the captured table is already stale.
        if (save_ack) begin
          pending_d  = 1'b0;
          idle_cnt_d = '0;
          state_d    = (pending_q || core_wr) ? ST_DIRTY : ST_CLEAN;
        end else if (core_wr) begin
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAN;
      end
    endcase
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      hs_rd_data_q   <= '0;
      core_rd_data_q <= '0;
      state_q        <= ST_CLEAN;
      idle_cnt_q     <= '0;
      pending_q      <= 1'b0;
    end else begin
      hs_rd_data_q   <= hs_rd_data_d;
      core_rd_data_q <= core_rd_data_d;
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      pending_q      <= pending_d;
    end
  end

  assign hs_rd_data   = hs_rd_data_q;
  assign core_rd_data = core_rd_data_q;
  assign save_req     = (state_q == ST_REQ);
  assign dirty        = (state_q != ST_CLEAN);

endmodule

// File: tb/tb_hiscore_bridge_buffer.sv
// Scoreboard bench for hiscore_bridge_buffer: byte-array memory model plus timestamp-based save-request model.
module tb_hiscore_bridge_buffer;

  localparam logic [31:0] BASE = 32'h0020_0000;
  localparam int          IDLE = 100;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bridge_addr = 32'h0020_0000;
  logic        bridge_wr = 1'b0;
  logic [31:0] bridge_wr_data = '0;
  logic        bridge_rd = 1'b0;
  logic        hs_selected;
  logic [31:0] hs_rd_data;
  logic [5:0]  core_addr = '0;
  logic        core_wr = 1'b0;
  logic [7:0]  core_wr_data = '0;
  logic [7:0]  core_rd_data;
  logic        save_req;
  logic        save_ack = 1'b0;
  logic        dirty;

  logic        core_chk = 1'b0;

  hiscore_bridge_buffer #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(16),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .bridge_addr   (bridge_addr),
    .bridge_wr     (bridge_wr),
    .bridge_wr_data(bridge_wr_data),
    .bridge_rd     (bridge_rd),
    .hs_selected   (hs_selected),
    .hs_rd_data    (hs_rd_data),
    .core_addr     (core_addr),
    .core_wr       (core_wr),
    .core_wr_data  (core_wr_data),
    .core_rd_data  (core_rd_data),
    .save_req      (save_req),
    .save_ack      (save_ack),
    .dirty         (dirty)
  );

  always #5 clk_74a = ~clk_74a;

  typedef struct {
    logic [31:0] hs;
    logic [7:0]  core;
    logic        dirty;
    logic        req;
    logic        chk_hs;
    logic        chk_core;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table as a flat big-endian byte array, save logic by timestamps.
  logic [7:0] m_bytes [64];
  logic       m_dirty = 1'b0;
  logic       m_req = 1'b0;
  logic       m_pending = 1'b0;
  int         m_last_wr = 0;
  int         cyc = 0;

  always @(posedge clk_74a) begin
    exp_t e;
    int   w;
    logic sel;
    cyc++;
    if (!reset_n) begin
      e = '{hs: 32'h0, core: 8'h0, dirty: 1'b0, req: 1'b0, chk_hs: 1'b1, chk_core: 1'b1};
      m_dirty = 1'b0;
      m_req = 1'b0;
      m_pending = 1'b0;
    end else begin
      w   = int'(bridge_addr[5:2]);
      sel = (bridge_addr >= BASE) && (bridge_addr < BASE + 32'd64);
      check("hs_selected", {31'b0, hs_selected}, {31'b0, sel});
      e.hs       = {m_bytes[4*w], m_bytes[4*w+1], m_bytes[4*w+2], m_bytes[4*w+3]};
      e.core     = m_bytes[core_addr];
      e.chk_hs   = bridge_rd;
      e.chk_core = core_chk;
      if (core_wr && !(bridge_wr && sel && (int'(core_addr[5:2]) == w)))
        m_bytes[core_addr] = core_wr_data;
      if (bridge_wr && sel)
        for (int k = 0; k < 4; k++) m_bytes[4*w+k] = bridge_wr_data[31-8*k -: 8];
      if (m_req) begin
        if (core_wr) m_pending = 1'b1;
        if (save_ack) begin
          m_req = 1'b0;
          m_dirty = m_pending;
          m_last_wr = cyc;
          m_pending = 1'b0;
        end
      end else if (core_wr) begin
        m_dirty = 1'b1;
        m_last_wr = cyc;
      end else if (m_dirty && (cyc - m_last_wr >= IDLE)) begin
        m_req = 1'b1;
      end
      e.dirty = m_dirty;
      e.req   = m_req;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk_74a) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dirty", {31'b0, dirty}, {31'b0, e.dirty});
      check("save_req", {31'b0, save_req}, {31'b0, e.req});
      if (e.chk_hs) check("hs_rd_data", hs_rd_data, e.hs);
      if (e.chk_core) check("core_rd_data", {24'b0, core_rd_data}, {24'b0, e.core});
    end
  end

  task automatic drive(input logic bw, input logic [31:0] ba, input logic [31:0] bd, input logic br,
                       input logic cw, input logic [5:0] ca, input logic [7:0] cd, input logic ack);
    bridge_wr      = bw;
    bridge_addr    = ba;
    bridge_wr_data = bd;
    bridge_rd      = br;
    core_wr        = cw;
    core_addr      = ca;
    core_wr_data   = cd;
    save_ack       = ack;
    @(negedge clk_74a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, BASE + 32'h4, 32'h0, 1'b1, 1'b0, 6'd5, 8'h0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, BASE, 32'h0, 1'b0, 1'b0, 6'd0, 8'h0, 1'b0);
    drive(1'b0, BASE, 32'h0, 1'b0, 1'b0, 6'd0, 8'h0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, BASE + 32'(4 * i), $urandom, 1'b0, 1'b0, 6'd0, 8'h0, 1'b0);
    core_chk = 1'b1;

    drive(1'b1, 32'h0020_0004, 32'hDEAD_BEEF, 1'b1, 1'b0, 6'd4, 8'h0, 1'b0);
    drive(1'b0, 32'h0020_0004, 32'h0, 1'b1, 1'b1, 6'd5, 8'h11, 1'b0);
    drive(1'b0, 32'h0020_0004, 32'h0, 1'b1, 1'b0, 6'd5, 8'h0, 1'b0);
    idle(105);
    drive(1'b0, BASE, 32'h0, 1'b1, 1'b0, 6'd0, 8'h0, 1'b1);
    idle(3);

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, BASE, 32'h0, 1'b1, 1'b1, 6'(i), 8'(i + 8'h40), 1'b0);
      idle(49);
    end
    idle(110);
    drive(1'b0, BASE, 32'h0, 1'b1, 1'b1, 6'd12, 8'h77, 1'b0);
    idle(2);
    drive(1'b0, BASE, 32'h0, 1'b1, 1'b0, 6'd0, 8'h0, 1'b1);
    idle(105);
    drive(1'b0, BASE, 32'h0, 1'b1, 1'b1, 6'd13, 8'h78, 1'b1);
    idle(105);

    drive(1'b1, 32'h0020_0008, 32'hCAFE_F00D, 1'b0, 1'b1, 6'd9, 8'h55, 1'b0);
    drive(1'b0, 32'h0020_0008, 32'h0, 1'b1, 1'b0, 6'd9, 8'h0, 1'b0);
    drive(1'b0, 32'h0020_0008, 32'h0, 1'b1, 1'b0, 6'd9, 8'h0, 1'b0);
    idle(101);

    reset_n = 1'b0;
    drive(1'b0, 32'h0020_0008, 32'h0, 1'b0, 1'b0, 6'd8, 8'h0, 1'b0);
    reset_n = 1'b1;
    drive(1'b0, 32'h0020_0008, 32'h0, 1'b1, 1'b0, 6'd8, 8'h0, 1'b0);
    drive(1'b1, 32'h0030_0000, 32'h1234_5678, 1'b0, 1'b0, 6'd0, 8'h0, 1'b0);
    drive(1'b0, 32'h0020_0000, 32'h0, 1'b1, 1'b0, 6'd0, 8'h0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] ba;
      logic        bw;
      logic        cw;
      ba = ($urandom_range(0, 7) == 0) ? (32'h0030_0000 | ($urandom & 32'hFC)) : (BASE + 32'($urandom_range(0, 63)));
      bw = ($urandom_range(0, 3) == 0);
      cw = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        reset_n = 1'b0;
        bw = 1'b0;
        cw = 1'b0;
      end else begin
        reset_n = 1'b1;
      end
      drive(bw, ba, $urandom, 1'($urandom), cw, 6'($urandom), 8'($urandom), ($urandom_range(0, 24) == 0));
    end
    reset_n = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
